// File: rtl/ripl_sched_pkg.sv
// Shared types and sizing helpers for the ProgNetwork frame scheduler.
package ripl_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INJECT = 2'd1,
    HOLD   = 2'd2,
    DRAIN  = 2'd3
  } sched_state_t;

  localparam int PERF_W = 32;

  function automatic int pix_per_frame(input int img_w, input int img_h);
    return img_w * img_h;
  endfunction

  // Counter width able to hold the value PIX itself (output side parks at PIX).
  function automatic int pix_cnt_width(input int pix);
    return $clog2(pix + 1);
  endfunction

endpackage

// File: rtl/ripl_out_chan_counter.sv
// One output channel: takes tokens while running and parks at PIX until the
// other channels catch up and the frame is released by clear.
module ripl_out_chan_counter #(
  parameter int PIX   = 100,
  parameter int PIX_W = 7
) (
  input  logic CLK,
  input  logic RESET,
  input  logic run_out,
  input  logic sink_ready,
  input  logic send,
  input  logic clear,
  output logic ack,
  output logic rdy,
  output logic full
);

  logic [PIX_W-1:0] count;

  assign full = (count == PIX_W'(PIX));
  assign rdy  = run_out & sink_ready & ~full;
  assign ack  = send & rdy;

  // Token count for the frame currently leaving this channel.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (ack) begin
      count <= count + PIX_W'(1);
    end
  end

endmodule

// File: rtl/ripl_sched_ack_checker.sv
// Simulation checks on the inject handshake: the network must ack exactly
// the cycles in which the scheduler commits a token.
module ripl_sched_ack_checker (
  input logic       CLK,
  input logic       RESET,
  input logic       inj,
  input logic [2:0] ack,
  input logic       err_ack
);

  a_ack_match: assert property (@(posedge CLK) disable iff (!RESET) ack == {3{inj}});
  a_no_err:    assert property (@(posedge CLK) disable iff (!RESET) !err_ack);

endmodule

// File: rtl/ripl_frame_scheduler.sv
// Frame scheduler for the three-channel ProgNetwork: lockstep frame injection,
// in-flight limiting and per-channel output counting.
// Optional stall counters are built when RIPL_SCHED_PERF_EN is defined.
module ripl_frame_scheduler
  import ripl_sched_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int IMG_W        = 10,
  parameter int IMG_H        = 10,
  parameter int MAX_INFLIGHT = 2,
  parameter int FCNT_W       = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                start,
  input  logic [FCNT_W-1:0]   num_frames,
  input  logic                stop,
  input  logic [3*DATA_W-1:0] src_data,
  input  logic                src_valid,
  output logic                src_ready,
  output logic [DATA_W-1:0]   In1_data,
  output logic [DATA_W-1:0]   In2_data,
  output logic [DATA_W-1:0]   In3_data,
  output logic                In1_send,
  output logic                In2_send,
  output logic                In3_send,
  input  logic                In1_ack,
  input  logic                In2_ack,
  input  logic                In3_ack,
  input  logic                In1_rdy,
  input  logic                In2_rdy,
  input  logic                In3_rdy,
  input  logic                Out1_send,
  input  logic                Out2_send,
  input  logic                Out3_send,
  output logic                Out1_ack,
  output logic                Out2_ack,
  output logic                Out3_ack,
  output logic                Out1_rdy,
  output logic                Out2_rdy,
  output logic                Out3_rdy,
  input  logic                sink_ready,
  output logic                busy,
  output logic                frame_in_done,
  output logic                frame_out_done,
  output logic [FCNT_W-1:0]   frames_in,
  output logic [FCNT_W-1:0]   frames_out,
  output logic [PERF_W-1:0]   perf_in_stall,
  output logic [PERF_W-1:0]   perf_out_stall
);

  localparam int PIX   = pix_per_frame(IMG_W, IMG_H);
  localparam int PIX_W = pix_cnt_width(PIX);

  sched_state_t      state;
  logic [PIX_W-1:0]  in_pix;
  logic [FCNT_W-1:0] target;
  logic              err_ack;

  logic              all_rdy;
  logic              inj;
  logic              last_in;
  logic              in_done_ev;
  logic              out_done_ev;
  logic              run_out;
  logic              start_ok;
  logic              out_clear;
  logic              end_nxt;
  logic              end_now;
  logic [FCNT_W-1:0] frames_in_nxt;
  logic [FCNT_W-1:0] frames_out_nxt;
  logic [FCNT_W-1:0] inflight;
  logic [FCNT_W-1:0] inflight_nxt;
  logic [2:0]        in_ack_v;
  logic [2:0]        out_send_v;
  logic [2:0]        out_ack_v;
  logic [2:0]        out_rdy_v;
  logic [2:0]        out_full;

  assign all_rdy     = In1_rdy & In2_rdy & In3_rdy;
  assign inj         = (state == INJECT) & src_valid & all_rdy;
  assign last_in     = (in_pix == PIX_W'(PIX - 1));
  assign in_done_ev  = inj & last_in;
  assign out_done_ev = &out_full;
  assign run_out     = (state != IDLE);
  assign start_ok    = (state == IDLE) & start;
  assign out_clear   = out_done_ev | start_ok;

  // Subtraction modulo 2^FCNT_W keeps the in-flight count right across wrap.
  assign frames_in_nxt  = frames_in + FCNT_W'(in_done_ev);
  assign frames_out_nxt = frames_out + FCNT_W'(out_done_ev);
  assign inflight       = frames_in - frames_out;
  assign inflight_nxt   = frames_in_nxt - frames_out_nxt;

  assign end_nxt = stop | ((target != '0) & (frames_in_nxt == target));
  assign end_now = stop | ((target != '0) & (frames_in == target));

  assign src_ready = inj;
  assign In1_send  = inj;
  assign In2_send  = inj;
  assign In3_send  = inj;
  assign In1_data  = src_data[0*DATA_W +: DATA_W];
  assign In2_data  = src_data[1*DATA_W +: DATA_W];
  assign In3_data  = src_data[2*DATA_W +: DATA_W];

  assign in_ack_v   = {In3_ack, In2_ack, In1_ack};
  assign out_send_v = {Out3_send, Out2_send, Out1_send};
  assign Out1_ack   = out_ack_v[0];
  assign Out2_ack   = out_ack_v[1];
  assign Out3_ack   = out_ack_v[2];
  assign Out1_rdy   = out_rdy_v[0];
  assign Out2_rdy   = out_rdy_v[1];
  assign Out3_rdy   = out_rdy_v[2];

  assign busy           = (state != IDLE);
  assign frame_in_done  = in_done_ev;
  assign frame_out_done = out_done_ev;

  for (genvar k = 0; k < 3; k++) begin : g_out
    ripl_out_chan_counter #(
      .PIX   (PIX),
      .PIX_W (PIX_W)
    ) u_chan (
      .CLK        (CLK),
      .RESET      (RESET),
      .run_out    (run_out),
      .sink_ready (sink_ready),
      .send       (out_send_v[k]),
      .clear      (out_clear),
      .ack        (out_ack_v[k]),
      .rdy        (out_rdy_v[k]),
      .full       (out_full[k])
    );
  end

  // Run sequencing, input pixel position and completed-frame counters.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= IDLE;
      in_pix     <= '0;
      frames_in  <= '0;
      frames_out <= '0;
      target     <= '0;
      err_ack    <= 1'b0;
    end else begin
      if (in_ack_v != {3{inj}}) begin
        err_ack <= 1'b1;
      end
      frames_in  <= frames_in_nxt;
      frames_out <= frames_out_nxt;
      if (inj) begin
        in_pix <= last_in ? '0 : in_pix + PIX_W'(1);
      end
      case (state)
        IDLE: begin
          // Counts are per run so the target compare starts from zero.
          if (start) begin
            state      <= INJECT;
            target     <= num_frames;
            in_pix     <= '0;
            frames_in  <= '0;
            frames_out <= '0;
          end
        end
        INJECT: begin
          if (in_done_ev) begin
            if (end_nxt) begin
              state <= DRAIN;
            end else if (inflight_nxt >= FCNT_W'(MAX_INFLIGHT)) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (end_now) begin
            state <= DRAIN;
          end else if (inflight < FCNT_W'(MAX_INFLIGHT)) begin
            state <= INJECT;
          end
        end
        DRAIN: begin
          if (frames_out_nxt == frames_in) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ripl_sched_ack_checker u_ack_chk (
    .CLK     (CLK),
    .RESET   (RESET),
    .inj     (inj),
    .ack     (in_ack_v),
    .err_ack (err_ack)
  );

`ifdef RIPL_SCHED_PERF_EN
  logic [PERF_W-1:0] in_stall_cnt;
  logic [PERF_W-1:0] out_stall_cnt;
  logic              in_stall_ev;
  logic              out_stall_ev;

  assign in_stall_ev  = (state == INJECT) & src_valid & ~all_rdy;
  assign out_stall_ev = |(out_send_v & ~out_rdy_v);

  // Saturating stall counters, restarted with each run.
  always_ff @(posedge CLK) begin
    if (!RESET || start_ok) begin
      in_stall_cnt  <= '0;
      out_stall_cnt <= '0;
    end else begin
      if (in_stall_ev && (in_stall_cnt != '1)) begin
        in_stall_cnt <= in_stall_cnt + PERF_W'(1);
      end
      if (out_stall_ev && (out_stall_cnt != '1)) begin
        out_stall_cnt <= out_stall_cnt + PERF_W'(1);
      end
    end
  end

  assign perf_in_stall  = in_stall_cnt;
  assign perf_out_stall = out_stall_cnt;
`else
  assign perf_in_stall  = '0;
  assign perf_out_stall = '0;
`endif

endmodule

// File: tb/tb_ripl_frame_scheduler.sv
// Directed bench for ripl_frame_scheduler (10x10 frames, MAX_INFLIGHT=2).
module tb_ripl_frame_scheduler;

  localparam int DATA_W = 8;
  localparam int FCNT_W = 16;

  logic                CLK;
  logic                RESET;
  logic                start;
  logic [FCNT_W-1:0]   num_frames;
  logic                stop;
  logic [3*DATA_W-1:0] src_data;
  logic                src_valid;
  logic                src_ready;
  logic [DATA_W-1:0]   In1_data, In2_data, In3_data;
  logic                In1_send, In2_send, In3_send;
  logic                In1_ack, In2_ack, In3_ack;
  logic                In1_rdy, In2_rdy, In3_rdy;
  logic                Out1_send, Out2_send, Out3_send;
  logic                Out1_ack, Out2_ack, Out3_ack;
  logic                Out1_rdy, Out2_rdy, Out3_rdy;
  logic                sink_ready;
  logic                busy;
  logic                frame_in_done;
  logic                frame_out_done;
  logic [FCNT_W-1:0]   frames_in, frames_out;
  logic [31:0]         perf_in_stall, perf_out_stall;

  logic [2:0] in_rdy;
  logic [2:0] out_send;

  int n_checks = 0;
  int n_err    = 0;

  // Network model: accepts every offered token, presents output tokens on demand.
  assign In1_rdy   = in_rdy[0];
  assign In2_rdy   = in_rdy[1];
  assign In3_rdy   = in_rdy[2];
  assign In1_ack   = In1_send;
  assign In2_ack   = In2_send;
  assign In3_ack   = In3_send;
  assign Out1_send = out_send[0];
  assign Out2_send = out_send[1];
  assign Out3_send = out_send[2];

  ripl_frame_scheduler dut (
    .CLK(CLK), .RESET(RESET), .start(start), .num_frames(num_frames), .stop(stop),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .In1_data(In1_data), .In2_data(In2_data), .In3_data(In3_data),
    .In1_send(In1_send), .In2_send(In2_send), .In3_send(In3_send),
    .In1_ack(In1_ack), .In2_ack(In2_ack), .In3_ack(In3_ack),
    .In1_rdy(In1_rdy), .In2_rdy(In2_rdy), .In3_rdy(In3_rdy),
    .Out1_send(Out1_send), .Out2_send(Out2_send), .Out3_send(Out3_send),
    .Out1_ack(Out1_ack), .Out2_ack(Out2_ack), .Out3_ack(Out3_ack),
    .Out1_rdy(Out1_rdy), .Out2_rdy(Out2_rdy), .Out3_rdy(Out3_rdy),
    .sink_ready(sink_ready), .busy(busy),
    .frame_in_done(frame_in_done), .frame_out_done(frame_out_done),
    .frames_in(frames_in), .frames_out(frames_out),
    .perf_in_stall(perf_in_stall), .perf_out_stall(perf_out_stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Event monitor, sampled on the falling edge.
  int   cyc = 0, inj_cnt = 0, fid_cnt = 0, fod_cnt = 0;
  int   last_fod_cyc = 0, fall_cyc = 0;
  int   ack1 = 0, ack2 = 0, ack3 = 0;
  int   fid_pos [8];
  logic prev_busy = 1'b0;

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (src_ready) inj_cnt <= inj_cnt + 1;
    if (frame_in_done) begin
      fid_pos[fid_cnt % 8] <= inj_cnt + 1;
      fid_cnt <= fid_cnt + 1;
    end
    if (frame_out_done) begin
      fod_cnt      <= fod_cnt + 1;
      last_fod_cyc <= cyc;
    end
    if (prev_busy && !busy) fall_cyc <= cyc;
    prev_busy <= busy;
    if (Out1_ack) ack1 <= ack1 + 1;
    if (Out2_ack) ack2 <= ack2 + 1;
    if (Out3_ack) ack3 <= ack3 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench 1ns into the first INJECT cycle.
  task automatic start_run(input logic [FCNT_W-1:0] nf);
    start      = 1'b1;
    num_frames = nf;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
    tick();
  endtask

  int b_inj, b_fid, b_fod, b_a1, b_a3, n;

  initial begin
    RESET = 1'b0; start = 1'b0; stop = 1'b0; num_frames = '0;
    src_valid = 1'b1; src_data = 24'h332211;
    in_rdy = 3'b111; out_send = 3'b111; sink_ready = 1'b1;
    repeat (3) tick();
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_src_ready", {31'd0, src_ready}, 32'd0);
    check("rst_in_send", {29'd0, In1_send, In2_send, In3_send}, 32'd0);
    check("rst_out_rdy", {29'd0, Out1_rdy, Out2_rdy, Out3_rdy}, 32'd0);
    check("rst_frames_in", {16'd0, frames_in}, 32'd0);
    check("rst_frames_out", {16'd0, frames_out}, 32'd0);
    check("rst_perf_in", perf_in_stall, 32'd0);
    RESET = 1'b1;
    tick();

    // Free-running three-frame run.
    b_inj = inj_cnt; b_fid = fid_cnt; b_fod = fod_cnt; b_a1 = ack1; b_a3 = ack3;
    start_run(16'd3);
    #1;
    check("run3_send", {31'd0, In1_send}, 32'd1);
    check("run3_data1", {24'd0, In1_data}, 32'h11);
    check("run3_data2", {24'd0, In2_data}, 32'h22);
    check("run3_data3", {24'd0, In3_data}, 32'h33);
    wait_idle(1000, "run3_idle");
    check("run3_inj", inj_cnt - b_inj, 32'd300);
    check("run3_fid_cnt", fid_cnt - b_fid, 32'd3);
    check("run3_fid_at1", fid_pos[b_fid % 8] - b_inj, 32'd100);
    check("run3_fid_at2", fid_pos[(b_fid + 1) % 8] - b_inj, 32'd200);
    check("run3_fid_at3", fid_pos[(b_fid + 2) % 8] - b_inj, 32'd300);
    check("run3_fod_cnt", fod_cnt - b_fod, 32'd3);
    check("run3_frames_in", {16'd0, frames_in}, 32'd3);
    check("run3_frames_out", {16'd0, frames_out}, 32'd3);
    check("run3_busy_fall", fall_cyc - last_fod_cyc, 32'd1);
    check("run3_out1_acks", ack1 - b_a1, 32'd300);
    check("run3_out3_acks", ack3 - b_a3, 32'd300);

    // In2_rdy low for five cycles mid-frame.
    start_run(16'd1);
    repeat (30) tick();
    in_rdy = 3'b101;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_sends", {28'd0, In1_send, In2_send, In3_send, src_ready}, 32'd0);
      tick();
    end
    in_rdy = 3'b111;
    #1;
    n = 36;
    while (!frame_in_done && n < 400) begin
      tick();
      n++;
    end
    check("stall_fid_cycle", n, 32'd105);
`ifdef RIPL_SCHED_PERF_EN
    check("stall_perf_in", perf_in_stall, 32'd5);
`else
    check("stall_perf_in", perf_in_stall, 32'd0);
`endif
    wait_idle(500, "stall_idle");

    // In-flight limit with the sink blocked.
    sink_ready = 1'b0;
    start_run(16'd3);
    repeat (210) tick();
    check("hold_busy", {31'd0, busy}, 32'd1);
    check("hold_src_ready", {31'd0, src_ready}, 32'd0);
    check("hold_frames_in", {16'd0, frames_in}, 32'd2);
    check("hold_frames_out", {16'd0, frames_out}, 32'd0);
    check("hold_out_rdy", {31'd0, Out1_rdy}, 32'd0);
    sink_ready = 1'b1;
    #1;
    n = 0;
    while (!src_ready && n < 400) begin
      tick();
      n++;
    end
    check("hold_resume_cycles", n, 32'd102);
    check("hold_resume_frames_out", {16'd0, frames_out}, 32'd1);
    wait_idle(1000, "hold_idle");
    check("hold_end_frames_out", {16'd0, frames_out}, 32'd3);

    // Skewed output channels: Out3 starts 20 cycles late.
    b_fod = fod_cnt;
    out_send = 3'b011;
    start_run(16'd2);
    repeat (20) tick();
    out_send = 3'b111;
    repeat (89) tick();
    check("skew_out1_parked", {31'd0, Out1_rdy}, 32'd0);
    check("skew_out3_rdy", {31'd0, Out3_rdy}, 32'd1);
    check("skew_no_fod", {31'd0, frame_out_done}, 32'd0);
    repeat (11) tick();
    check("skew_fod", {31'd0, frame_out_done}, 32'd1);
    tick();
    check("skew_fod_pulse", {31'd0, frame_out_done}, 32'd0);
    check("skew_out1_cleared", {31'd0, Out1_rdy}, 32'd1);
    check("skew_frames_out", {16'd0, frames_out}, 32'd1);
    wait_idle(500, "skew_idle");
    check("skew_fod_total", fod_cnt - b_fod, 32'd2);

    // stop mid-frame in continuous mode.
    b_inj = inj_cnt; b_fid = fid_cnt;
    start_run(16'd0);
    repeat (37) tick();
    stop = 1'b1;
    wait_idle(400, "stop_idle");
    stop = 1'b0;
    check("stop_inj", inj_cnt - b_inj, 32'd100);
    check("stop_fid", fid_cnt - b_fid, 32'd1);
    check("stop_frames_in", {16'd0, frames_in}, 32'd1);
    check("stop_frames_out", {16'd0, frames_out}, 32'd1);

    // Reset in the middle of the second frame, then restart.
    start_run(16'd0);
    repeat (150) tick();
    check("mid_frames_in", {16'd0, frames_in}, 32'd1);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_frames_in", {16'd0, frames_in}, 32'd0);
    check("mrst_frames_out", {16'd0, frames_out}, 32'd0);
    check("mrst_src_ready", {31'd0, src_ready}, 32'd0);
    check("mrst_out_rdy", {31'd0, Out1_rdy}, 32'd0);
    check("mrst_perf_in", perf_in_stall, 32'd0);
    check("mrst_perf_out", perf_out_stall, 32'd0);
    tick();
    b_inj = inj_cnt; b_fid = fid_cnt;
    start_run(16'd1);
    wait_idle(500, "restart_idle");
    check("restart_fid_at", fid_pos[b_fid % 8] - b_inj, 32'd100);
    check("restart_frames_in", {16'd0, frames_in}, 32'd1);
    check("restart_frames_out", {16'd0, frames_out}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
